// File: rtl/ring_osc_freq_counter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ring_osc_freq_counter_if
//  Brief    : Register-side bundle of the ring-oscillator frequency counter.
//             The continuous port exists only with
//             RING_OSC_FREQ_COUNTER_CONTINUOUS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
interface ring_osc_freq_counter_if #(
    parameter int GATE_WIDTH  = 16,
    parameter int COUNT_WIDTH = 24
);
    logic                   start;
    logic [GATE_WIDTH-1:0]  gate_cycles;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] count;
    logic                   overflow;
`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
    logic                   continuous;

    modport master (
        output start, gate_cycles, continuous,
        input  busy, done, count, overflow
    );
    modport slave (
        input  start, gate_cycles, continuous,
        output busy, done, count, overflow
    );
`else
    modport master (
        output start, gate_cycles,
        input  busy, done, count, overflow
    );
    modport slave (
        input  start, gate_cycles,
        output busy, done, count, overflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ring_osc_freq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ring_osc_freq_counter
//  Brief    : Prescales a free-running ring oscillator, synchronises it into
//             clk and counts its rising edges over a programmable gate window.
//             Optional macro RING_OSC_FREQ_COUNTER_CONTINUOUS_EN adds
//             back-to-back (continuous) measurement.
//  Revision : 1.0 - initial release
// ============================================================================
module ring_osc_freq_counter #(
    parameter int GATE_WIDTH    = 16,
    parameter int COUNT_WIDTH   = 24,
    parameter int PRESCALE      = 4,
    parameter int WARMUP_CYCLES = 16
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  osc_out,
    output logic osc_en,
    ring_osc_freq_counter_if.slave bus
);

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [GATE_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
    logic [WARM_W-1:0]      warm_cnt_q, warm_cnt_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [PRESCALE-1:0]    presc_q, presc_d;
    logic [2:0]             sync_q, sync_d;
    logic                   div_clk;
    logic                   edge_det;
    logic                   cont_mode;
    logic                   busy_c;
    logic                   done_c;

`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
    assign cont_mode = bus.continuous;
`else
    assign cont_mode = 1'b0;
`endif

    // Oscillator-domain divider; only its MSB crosses into clk.
    always_comb presc_d = presc_q + PRESCALE'(1);

    always_ff @(posedge osc_out or posedge reset) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    assign div_clk  = presc_q[PRESCALE-1];
    assign sync_d   = {sync_q[1:0], div_clk};
    assign edge_det = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gate_cnt_q <= '0;
            warm_cnt_q <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sync_q     <= sync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        warm_cnt_d = warm_cnt_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        osc_en     = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    gate_cnt_d = bus.gate_cycles;
                    acc_d      = '0;
                    ovf_acc_d  = 1'b0;
                    warm_cnt_d = WARM_LOAD;
                    state_d    = S_WARMUP;
                end
            end
            S_WARMUP: begin
                osc_en = 1'b1;
                busy_c = 1'b1;
                if (warm_cnt_q == '0) begin
                    state_d = (gate_cnt_q == '0) ? S_DONE : S_MEASURE;
                end else begin
                    warm_cnt_d = warm_cnt_q - WARM_W'(1);
                end
            end
            S_MEASURE: begin
                osc_en = 1'b1;
                busy_c = 1'b1;
                // Saturate rather than wrap so a too-fast oscillator is flagged.
                if (edge_det) begin
                    if (&acc_q) ovf_acc_d = 1'b1;
                    else        acc_d     = acc_q + COUNT_WIDTH'(1);
                end
                gate_cnt_d = gate_cnt_q - GATE_WIDTH'(1);
                if (gate_cnt_q <= GATE_WIDTH'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                done_c     = 1'b1;
                count_d    = acc_q;
                overflow_d = ovf_acc_q;
                osc_en     = cont_mode;
                busy_c     = cont_mode;
                if (cont_mode) begin
                    gate_cnt_d = bus.gate_cycles;
                    acc_d      = '0;
                    ovf_acc_d  = 1'b0;
                    state_d    = (bus.gate_cycles == '0) ? S_DONE : S_MEASURE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_freq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ring_osc_freq_counter
//  Brief    : Directed self-checking bench; instance a is the default build,
//             instance b uses a 4-bit result counter for saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_osc_freq_counter;

    localparam int WARM = 16;

    logic clk;
    logic reset;
    logic osc_out;
    logic osc_en_a;
    logic osc_en_b;
    int   cyc;
    int   n_checks;
    int   n_err;

    ring_osc_freq_counter_if #(.GATE_WIDTH(16), .COUNT_WIDTH(24)) if_a ();
    ring_osc_freq_counter_if #(.GATE_WIDTH(16), .COUNT_WIDTH(4))  if_b ();

    ring_osc_freq_counter #(
        .GATE_WIDTH(16), .COUNT_WIDTH(24), .PRESCALE(4), .WARMUP_CYCLES(WARM)
    ) u_dut_a (
        .clk(clk), .reset(reset), .osc_out(osc_out), .osc_en(osc_en_a), .bus(if_a)
    );

    ring_osc_freq_counter #(
        .GATE_WIDTH(16), .COUNT_WIDTH(4), .PRESCALE(4), .WARMUP_CYCLES(WARM)
    ) u_dut_b (
        .clk(clk), .reset(reset), .osc_out(osc_out), .osc_en(osc_en_b), .bus(if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 2.5 ns oscillator, offset so divided edges never coincide with clk edges.
    initial begin
        osc_out = 1'b0;
        #0.3;
        forever #1.25 osc_out = ~osc_out;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Launch one measurement and wait (bounded) for its done pulse. Cycle
    // numbers are relative to the start cycle; returns one cycle after done.
    task automatic run_meas(input bit sel_b, input int gate, input int late_at,
                            output int done_at, output int en_first, output int en_last);
        int  t0;
        int  limit;
        bit  fin;
        @(negedge clk);
        if (sel_b) begin
            if_b.start       = 1'b1;
            if_b.gate_cycles = 16'(gate);
        end else begin
            if_a.start       = 1'b1;
            if_a.gate_cycles = 16'(gate);
        end
        t0       = cyc;
        done_at  = -1;
        en_first = -1;
        en_last  = -1;
        fin      = 1'b0;
        limit    = gate + WARM + 40;
        for (int k = 1; k <= limit && !fin; k++) begin
            @(negedge clk);
            if_a.start = 1'b0;
            if_b.start = 1'b0;
            if (k == late_at) begin
                if_a.start       = 1'b1;
                if_a.gate_cycles = 16'd5;
            end
            if (sel_b ? osc_en_b : osc_en_a) begin
                if (en_first < 0) en_first = cyc - t0;
                en_last = cyc - t0;
            end
            if (sel_b ? if_b.done : if_a.done) begin
                done_at = cyc - t0;
                fin     = 1'b1;
            end
        end
        @(negedge clk);
        if_a.start = 1'b0;
        if_b.start = 1'b0;
    endtask

    int d_at;
    int e_first;
    int e_last;
    int c;
    int seen;

    initial begin
        n_checks         = 0;
        n_err            = 0;
        reset            = 1'b1;
        if_a.start       = 1'b0;
        if_a.gate_cycles = '0;
        if_b.start       = 1'b0;
        if_b.gate_cycles = '0;
`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
        if_a.continuous  = 1'b0;
        if_b.continuous  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_osc_en",   32'(osc_en_a),      0);
        check("rst_busy",     32'(if_a.busy),     0);
        check("rst_done",     32'(if_a.done),     0);
        check("rst_count",    32'(if_a.count),    0);
        check("rst_overflow", 32'(if_a.overflow), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal 1000-cycle window, with an ignored start at cycle 100.
        run_meas(1'b0, 1000, 100, d_at, e_first, e_last);
        c = int'(if_a.count);
        check("nom_done_cycle", 32'(d_at), 1017);
        check($sformatf("nom_count_249_251 count=%0d", c), 32'(c >= 249 && c <= 251), 1);
        check("nom_overflow", 32'(if_a.overflow), 0);
        check("nom_osc_en_first", 32'(e_first), 1);
        check("nom_osc_en_last",  32'(e_last), 1016);
        check("nom_busy_after",   32'(if_a.busy), 0);
        check("nom_osc_en_after", 32'(osc_en_a), 0);

        // Asynchronous reset in the middle of MEASURE.
        @(negedge clk);
        if_a.start       = 1'b1;
        if_a.gate_cycles = 16'd1000;
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (200) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_osc_en",   32'(osc_en_a),      0);
        check("midrst_busy",     32'(if_a.busy),     0);
        check("midrst_done",     32'(if_a.done),     0);
        check("midrst_count",    32'(if_a.count),    0);
        check("midrst_overflow", 32'(if_a.overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (1100) begin
            @(negedge clk);
            if (if_a.done) seen++;
        end
        check("midrst_no_done", 32'(seen), 0);

        // Zero-length window.
        run_meas(1'b0, 0, -1, d_at, e_first, e_last);
        check("zero_done_cycle", 32'(d_at), 17);
        check("zero_count",      32'(if_a.count), 0);
        check("zero_overflow",   32'(if_a.overflow), 0);

        // Saturation on the 4-bit counter, then a clean short run.
        run_meas(1'b1, 200, -1, d_at, e_first, e_last);
        check("sat_done_cycle", 32'(d_at), 217);
        check("sat_count",      32'(if_b.count), 15);
        check("sat_overflow",   32'(if_b.overflow), 1);
        run_meas(1'b1, 20, -1, d_at, e_first, e_last);
        c = int'(if_b.count);
        check("short_overflow", 32'(if_b.overflow), 0);
        check($sformatf("short_count_4_6 count=%0d", c), 32'(c >= 4 && c <= 6), 1);

`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
        begin
            int last;
            int drops;
            bit got;
            if_a.continuous = 1'b1;
            run_meas(1'b0, 100, -1, d_at, e_first, e_last);
            check("cont_first_done", 32'(d_at), 117);
            last  = cyc - 1;
            drops = 0;
            for (int w = 0; w < 3; w++) begin
                got = 1'b0;
                for (int k = 0; k < 150 && !got; k++) begin
                    @(negedge clk);
                    if (!osc_en_a) drops++;
                    if (if_a.done) begin
                        check($sformatf("cont_period_%0d", w), 32'(cyc - last), 101);
                        last = cyc;
                        got  = 1'b1;
                    end
                end
                check($sformatf("cont_done_seen_%0d", w), 32'(got), 1);
                @(negedge clk);
                if (!osc_en_a) drops++;
                c = int'(if_a.count);
                check($sformatf("cont_count_24_26_%0d count=%0d", w, c),
                      32'(c >= 24 && c <= 26), 1);
            end
            check("cont_osc_en_drops", 32'(drops), 0);
            if_a.continuous = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 150 && !got; k++) begin
                @(negedge clk);
                if (if_a.done) got = 1'b1;
            end
            @(negedge clk);
            check("cont_stop_osc_en", 32'(osc_en_a), 0);
            check("cont_stop_busy",   32'(if_a.busy), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
